jk_drive_sequencer: RTL and testbench

//   Inverse of the JK register: from a stream of target state words, generates
//   the J/K excitation vectors that move a bank of WIDTH JK flip-flops to each

---
 rtl/jk_drive_sequencer_pkg.sv | 34 +++
 rtl/jk_drive_sequencer_if.sv | 11 +
 rtl/jk_drive_sequencer_fifo.sv | 65 ++++++
 rtl/jk_drive_sequencer.sv | 143 ++++++++++++++
 tb/tb_jk_drive_sequencer.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/jk_drive_sequencer_pkg.sv
// Shared types and helpers for the JK drive sequencer: FSM states,
// per-bit excitation codes and the excitation function.
package jk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_CHECK = 2'd2,
        ST_ERR   = 2'd3
    } state_e;

    // Per-bit {J,K} codes
    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_RST  = 2'b01;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_TGL  = 2'b11;

    // {J,K} that moves one flop from q to t; toggle_mode uses J=K=1 for any change.
    function automatic logic [1:0] jk_excite(input logic q, input logic t, input logic toggle_mode);
        logic [1:0] code;
        code = JK_HOLD;
        if (q == t) begin
            code = JK_HOLD;
        end else if (toggle_mode) begin
            code = JK_TGL;
        end else if (t) begin
            code = JK_SET;
        end else begin
            code = JK_RST;
        end
        return code;
    endfunction

endpackage

// File: rtl/jk_drive_sequencer_if.sv
// Target-word handshake between the pattern source and the sequencer.
interface jk_drive_sequencer_if #(
    parameter int WIDTH = 4
) ();
    logic             tgt_valid;
    logic             tgt_ready;
    logic [WIDTH-1:0] tgt_data;

    modport master (output tgt_valid, output tgt_data, input tgt_ready);
    modport slave  (input tgt_valid, input tgt_data, output tgt_ready);
endinterface

// File: rtl/jk_drive_sequencer_fifo.sv
// Synchronous target FIFO; pointers carry one extra bit so full and
// empty are distinguishable when the index bits coincide.
module jk_tgt_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic             push_ok_s, pop_ok_s;

    assign empty     = (wptr_q == rptr_q);
    assign full      = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    // A full FIFO refuses a push even when a pop happens in the same cycle.
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;
    assign rdata     = mem_q[rptr_q[AW-1:0]];

    // Next storage contents and pointer values.
    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push_ok_s) begin
            mem_d[wptr_q[AW-1:0]] = wdata;
            wptr_d                = wptr_q + PTR_ONE;
        end else begin
            wptr_d = wptr_q;
        end
        if (pop_ok_s) begin
            rptr_d = rptr_q + PTR_ONE;
        end else begin
            rptr_d = rptr_q;
        end
    end

    // Storage and pointer registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q <= {(AW+1){1'b0}};
            rptr_q <= {(AW+1){1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            mem_q  <= mem_d;
        end
    end

endmodule

// File: rtl/jk_drive_sequencer.sv
// Turns a stream of target Q words into one-cycle J/K excitation pulses
// for a JK flop bank, tracks the expected bank state and checks the
// fed-back Q one cycle after each pulse.
module jk_drive_sequencer
    import jk_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int DEPTH       = 4,
    parameter int TOGGLE_MODE = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    jk_drive_sequencer_if.slave  tgt,
    output logic [WIDTH-1:0]     j,
    output logic [WIDTH-1:0]     k,
    output logic                 jk_valid,
    input  logic [WIDTH-1:0]     q_obs,
    output logic [WIDTH-1:0]     q_model,
    output logic                 busy,
    output logic                 mismatch,
    output logic [WIDTH-1:0]     mis_bits,
    input  logic                 err_clr,
    output logic [15:0]          done_cnt
);
    localparam logic TGL = (TOGGLE_MODE != 0);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] j_q, j_d, k_q, k_d;
    logic             jk_valid_q, jk_valid_d;
    logic [WIDTH-1:0] q_model_q, q_model_d;
    logic             mismatch_q, mismatch_d;
    logic [WIDTH-1:0] mis_bits_q, mis_bits_d;
    logic [15:0]      done_cnt_q, done_cnt_d;
    logic             fifo_full_s, fifo_empty_s, fifo_pop_s;
    logic [WIDTH-1:0] fifo_rdata_s;
    logic [1:0]       exc_s;

    // Held low during reset so nothing is accepted while the FIFO is being cleared.
    assign tgt.tgt_ready = rst_n && !fifo_full_s;

    jk_tgt_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (tgt.tgt_valid && tgt.tgt_ready),
        .pop   (fifo_pop_s),
        .wdata (tgt.tgt_data),
        .rdata (fifo_rdata_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // Sequencer FSM: pop and excite in IDLE, pulse in DRIVE, verify in CHECK.
    always_comb begin
        state_d    = state_q;
        j_d        = {WIDTH{1'b0}};
        k_d        = {WIDTH{1'b0}};
        jk_valid_d = 1'b0;
        q_model_d  = q_model_q;
        mismatch_d = mismatch_q;
        mis_bits_d = mis_bits_q;
        done_cnt_d = done_cnt_q;
        fifo_pop_s = 1'b0;
        exc_s      = JK_HOLD;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    fifo_pop_s = 1'b1;
                    for (int i = 0; i < WIDTH; i++) begin
                        exc_s  = jk_excite(q_model_q[i], fifo_rdata_s[i], TGL);
                        j_d[i] = exc_s[1];
                        k_d[i] = exc_s[0];
                    end
                    jk_valid_d = 1'b1;
                    q_model_d  = fifo_rdata_s;
                    state_d    = ST_DRIVE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRIVE: begin
                // The bank samples the pulse at the edge closing this cycle.
                state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (q_obs == q_model_q) begin
                    done_cnt_d = done_cnt_q + 16'd1;
                    state_d    = ST_IDLE;
                end else begin
                    // Resync to what the bank really holds so later excitations are correct.
                    mismatch_d = 1'b1;
                    mis_bits_d = q_obs ^ q_model_q;
                    q_model_d  = q_obs;
                    state_d    = ST_ERR;
                end
            end
            ST_ERR: begin
                if (err_clr) begin
                    mismatch_d = 1'b0;
                    mis_bits_d = {WIDTH{1'b0}};
                    state_d    = ST_IDLE;
                end else begin
                    state_d = ST_ERR;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            j_q        <= {WIDTH{1'b0}};
            k_q        <= {WIDTH{1'b0}};
            jk_valid_q <= 1'b0;
            q_model_q  <= {WIDTH{1'b0}};
            mismatch_q <= 1'b0;
            mis_bits_q <= {WIDTH{1'b0}};
            done_cnt_q <= 16'd0;
        end else begin
            state_q    <= state_d;
            j_q        <= j_d;
            k_q        <= k_d;
            jk_valid_q <= jk_valid_d;
            q_model_q  <= q_model_d;
            mismatch_q <= mismatch_d;
            mis_bits_q <= mis_bits_d;
            done_cnt_q <= done_cnt_d;
        end
    end

    assign j        = j_q;
    assign k        = k_q;
    assign jk_valid = jk_valid_q;
    assign q_model  = q_model_q;
    assign mismatch = mismatch_q;
    assign mis_bits = mis_bits_q;
    assign done_cnt = done_cnt_q;
    assign busy     = (state_q != ST_IDLE) || !fifo_empty_s;

endmodule

// File: tb/tb_jk_drive_sequencer.sv
// Bench: two sequencers (set/reset and toggle excitation) fed the same
// target stream, each driving its own behavioural JK bank.
module tb_jk_drive_sequencer;
    localparam int W = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n, err_clr, force_zero, tv;
    logic [W-1:0] td;
    logic [W-1:0] j0, k0, j1, k1, qm0, qm1, mb0, mb1, bank0, bank1, qobs0, qobs1;
    logic         jv0, jv1, busy0, busy1, mis0, mis1;
    logic [15:0]  dc0, dc1;
    logic [W-1:0] mq;
    logic [15:0]  model_done;
    int           n_chk = 0;
    int           n_fail = 0;
    logic [W-1:0] q_fifo[$];

    jk_drive_sequencer_if #(.WIDTH(W)) if0 ();
    jk_drive_sequencer_if #(.WIDTH(W)) if1 ();
    assign if0.tgt_valid = tv;
    assign if0.tgt_data  = td;
    assign if1.tgt_valid = tv;
    assign if1.tgt_data  = td;
    assign qobs0 = force_zero ? {W{1'b0}} : bank0;
    assign qobs1 = force_zero ? {W{1'b0}} : bank1;

    jk_drive_sequencer #(.WIDTH(W), .DEPTH(4), .TOGGLE_MODE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .tgt(if0), .j(j0), .k(k0), .jk_valid(jv0),
        .q_obs(qobs0), .q_model(qm0), .busy(busy0), .mismatch(mis0),
        .mis_bits(mb0), .err_clr(err_clr), .done_cnt(dc0));

    jk_drive_sequencer #(.WIDTH(W), .DEPTH(4), .TOGGLE_MODE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .tgt(if1), .j(j1), .k(k1), .jk_valid(jv1),
        .q_obs(qobs1), .q_model(qm1), .busy(busy1), .mismatch(mis1),
        .mis_bits(mb1), .err_clr(err_clr), .done_cnt(dc1));

    // JK characteristic equation: Q+ = J & ~Q | ~K & Q
    function automatic logic [W-1:0] jk_next(input logic [W-1:0] q, input logic [W-1:0] jj,
                                             input logic [W-1:0] kk);
        return (jj & ~q) | (~kk & q);
    endfunction

    // Required {J,K} vectors moving q to t
    function automatic logic [2*W-1:0] exp_jk(input logic [W-1:0] q, input logic [W-1:0] t,
                                              input logic tgl);
        logic [W-1:0] jj, kk;
        if (tgl) begin
            jj = q ^ t;
            kk = q ^ t;
        end else begin
            jj = t & ~q;
            kk = q & ~t;
        end
        return {jj, kk};
    endfunction

    // Behavioural JK banks, reset together with the sequencers
    always @(posedge clk) begin
        if (!rst_n) begin
            bank0 <= {W{1'b0}};
            bank1 <= {W{1'b0}};
        end else begin
            bank0 <= jk_next(bank0, j0, k0);
            bank1 <= jk_next(bank1, j1, k1);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [W-1:0] d);
        int n = 0;
        tv = 1'b1;
        td = d;
        #1;
        while (!if0.tgt_ready && n < 60) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("push_accept", 32'(n < 60), 32'd1);
        @(negedge clk);
        tv = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((busy0 || busy1) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(n < 100), 32'd1);
    endtask

    task automatic wait_jv(input string tag);
        int n = 0;
        while (!jv0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(n < 60), 32'd1);
    endtask

    // Push one target, check the single excitation pulse and the settled model
    task automatic drive(input string tag, input logic [W-1:0] t,
                         output logic [W-1:0] oj0, output logic [W-1:0] ok0,
                         output logic [W-1:0] oj1, output logic [W-1:0] ok1);
        push(t);
        wait_jv({tag, "_wait"});
        chk({tag, "_jk0"}, 32'({j0, k0}), 32'(exp_jk(mq, t, 1'b0)));
        chk({tag, "_jk1"}, 32'({j1, k1}), 32'(exp_jk(mq, t, 1'b1)));
        chk({tag, "_jv1"}, 32'(jv1), 32'd1);
        oj0 = j0; ok0 = k0; oj1 = j1; ok1 = k1;
        mq = t;
        @(negedge clk);
        chk({tag, "_pulse_end"}, 32'({jv0, jv1, j0, k0, j1, k1}), 32'd0);
        wait_idle({tag, "_idle"});
        chk({tag, "_qm"}, 32'({qm0, qm1}), 32'({t, t}));
        chk({tag, "_nomis"}, 32'({mis0, mis1}), 32'd0);
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        repeat (cycles) @(negedge clk);
        rst_n = 1'b1;
        mq = {W{1'b0}};
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] a, b, c, d;
        int pulses;
        rst_n = 1'b0; err_clr = 1'b0; force_zero = 1'b0; tv = 1'b0; td = {W{1'b0}};
        mq = {W{1'b0}}; model_done = 16'd0;

        // 1: reset state
        repeat (2) @(negedge clk);
        chk("rst_jk", 32'({j0, k0, j1, k1}), 32'd0);
        chk("rst_jv", 32'({jv0, jv1}), 32'd0);
        chk("rst_qm", 32'({qm0, qm1}), 32'd0);
        chk("rst_err", 32'({mis0, mis1, mb0, mb1}), 32'd0);
        chk("rst_dc", 32'({dc0, dc1}), 32'd0);
        chk("rst_ready", 32'({if0.tgt_ready, if1.tgt_ready}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_ready", 32'({if0.tgt_ready, if1.tgt_ready}), 32'd3);

        // 2: set/reset excitation sequence
        drive("t2a", 4'b1010, a, b, c, d);
        chk("t2a_j0", 32'(a), 32'(4'b1010));
        chk("t2a_k0", 32'(b), 32'(4'b0000));
        drive("t2b", 4'b0110, a, b, c, d);
        chk("t2b_j0", 32'(a), 32'(4'b0100));
        chk("t2b_k0", 32'(b), 32'(4'b1000));
        chk("t2_dc", 32'({dc0, dc1}), {16'd2, 16'd2});

        // 3: toggle excitation from 1010 to 0110
        drive("t3a", 4'b1010, a, b, c, d);
        drive("t3b", 4'b0110, a, b, c, d);
        chk("t3_j1", 32'(c), 32'(4'b1100));
        chk("t3_k1", 32'(d), 32'(4'b1100));
        chk("t3_dc", 32'({dc0, dc1}), {16'd4, 16'd4});

        // 4: mismatch with the bank feedback stuck at zero
        force_zero = 1'b1;
        push(4'b1010);
        pulses = 0;
        while (!mis0 && pulses < 40) begin
            @(negedge clk);
            pulses++;
        end
        chk("t4_mis", 32'({mis0, mis1}), 32'd3);
        chk("t4_bits", 32'({mb0, mb1}), 32'({4'b1010, 4'b1010}));
        chk("t4_qm", 32'({qm0, qm1}), 32'd0);
        mq = {W{1'b0}};
        for (int i = 0; i < 4; i++) begin
            push(4'b0000);
            chk("t4_err_nojv", 32'({jv0, jv1}), 32'd0);
        end
        chk("t4_full", 32'({if0.tgt_ready, if1.tgt_ready}), 32'd0);
        chk("t4_sticky", 32'({mis0, mis1, busy0, busy1}), 32'hF);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("t4_clr", 32'({mis0, mis1, mb0, mb1}), 32'd0);
        pulses = 0;
        for (int n = 0; n < 60 && (busy0 || busy1); n++) begin
            @(negedge clk);
            if (jv0) pulses++;
        end
        chk("t4_drain_pulses", 32'(pulses), 32'd4);
        chk("t4_drain_idle", 32'({busy0, busy1}), 32'd0);
        chk("t4_dc", 32'({dc0, dc1}), {16'd8, 16'd8});
        force_zero = 1'b0;

        // 5: reset while checking, with three targets still queued
        do_reset(1);
        for (int i = 0; i < 5; i++) push(4'($urandom));
        wait_jv("t5_wait");
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t5_jv", 32'({jv0, jv1}), 32'd0);
        chk("t5_busy", 32'({busy0, busy1}), 32'd0);
        chk("t5_dc", 32'({dc0, dc1}), 32'd0);
        chk("t5_ready_in_rst", 32'({if0.tgt_ready, if1.tgt_ready}), 32'd0);
        rst_n = 1'b1;
        mq = {W{1'b0}};
        @(negedge clk);
        chk("t5_empty", 32'({busy0, busy1, jv0, jv1}), 32'd0);

        // 6: done_cnt wrap from 0xFFFE
        force dut0.done_cnt_d = 16'hFFFE;
        force dut1.done_cnt_d = 16'hFFFE;
        @(negedge clk);
        release dut0.done_cnt_d;
        release dut1.done_cnt_d;
        chk("t6_preload", 32'({dc0, dc1}), {16'hFFFE, 16'hFFFE});
        drive("t6a", 4'($urandom), a, b, c, d);
        chk("t6_ffff", 32'({dc0, dc1}), {16'hFFFF, 16'hFFFF});
        drive("t6b", mq, a, b, c, d);
        chk("t6_wrap", 32'({dc0, dc1}), 32'd0);

        // Random stream against the queue-based reference model
        do_reset(1);
        model_done = 16'd0;
        q_fifo.delete();
        for (int cyc = 0; cyc < 200; cyc++) begin
            @(negedge clk);
            if (jv0) begin
                chk("rnd_jv_pair", 32'(jv1), 32'd1);
                chk("rnd_have_target", 32'(q_fifo.size() > 0), 32'd1);
                if (q_fifo.size() > 0) begin
                    a = q_fifo.pop_front();
                    chk("rnd_jk0", 32'({j0, k0}), 32'(exp_jk(mq, a, 1'b0)));
                    chk("rnd_jk1", 32'({j1, k1}), 32'(exp_jk(mq, a, 1'b1)));
                    chk("rnd_qm", 32'({qm0, qm1}), 32'({a, a}));
                    chk("rnd_dc", 32'(dc0), 32'(model_done));
                    mq = a;
                    model_done = model_done + 16'd1;
                end
            end else begin
                chk("rnd_quiet", 32'({jv1, j0, k0, j1, k1}), 32'd0);
            end
            chk("rnd_nomis", 32'({mis0, mis1}), 32'd0);
            tv = (cyc < 170) && ($urandom_range(0, 2) != 0);
            td = 4'($urandom);
            #1;
            chk("rnd_ready_pair", 32'(if1.tgt_ready), 32'(if0.tgt_ready));
            if (tv && if0.tgt_ready) q_fifo.push_back(td);
        end
        tv = 1'b0;
        @(negedge clk);
        while ((busy0 || busy1) && q_fifo.size() > 0 && n_chk < 100000) begin
            if (jv0) begin
                a = q_fifo.pop_front();
                chk("rnd_tail_jk0", 32'({j0, k0}), 32'(exp_jk(mq, a, 1'b0)));
                chk("rnd_tail_jk1", 32'({j1, k1}), 32'(exp_jk(mq, a, 1'b1)));
                mq = a;
                model_done = model_done + 16'd1;
            end
            @(negedge clk);
        end
        wait_idle("rnd_idle");
        chk("rnd_drained", 32'(q_fifo.size()), 32'd0);
        chk("rnd_final_dc", 32'({dc0, dc1}), {model_done, model_done});
        chk("rnd_final_qm", 32'({qm0, qm1}), 32'({mq, mq}));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
